// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, with a single registered result slot.
// Define ALU_ARBITER_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant0;
    logic   grant1;
    logic   can_accept;
    logic   accept;

`ifdef ALU_ARBITER_RR_EN
    // Pointer remembers the last accepted requester; reset value 1 lets requester 0 win the first tie.
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A full slot can be refilled in the same cycle it is drained, giving one result per cycle.
    always_comb begin
        can_accept = (state == EMPTY) || rsp_ready;
        accept     = (grant0 || grant1) && can_accept;
        req0_ready = grant0 && can_accept;
        req1_ready = grant1 && can_accept;
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    always_comb begin
        alu_in1    = '0;
        alu_in2    = '0;
        alu_opcode = 4'd0;
        if (grant0) begin
            alu_in1    = req0_a;
            alu_in2    = req0_b;
            alu_opcode = req0_op;
        end else if (grant1) begin
            alu_in1    = req1_a;
            alu_in2    = req1_b;
            alu_opcode = req1_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else if (accept) begin
            rsp_data <= alu_out;
            rsp_id   <= grant1;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter; builds with or without ALU_ARBITER_RR_EN.
// The bench provides the shared ALU and an abstract model of the result slot and arbitration.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SLL = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_SUB = 4'd8;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;

    int compared = 0;
    int mismatched = 0;

    // Abstract model: one result slot plus the id of the last accepted requester.
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_id    = 1'b0;
    logic        m_last  = 1'b1;

    alu_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_opcode, alu_in1, alu_in2);

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [7];
        ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_XOR, OP_OR, OP_AND};
        return ops[$urandom_range(0, 6)];
    endfunction

    // Which requester wins the tie-break, ignoring whether the slot has room: bit0 = req0, bit1 = req1.
    function automatic logic [1:0] model_winner();
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_RR_EN
            return m_last ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return {req1_valid, req0_valid};
    endfunction

    function automatic logic [1:0] model_ready();
        if (m_valid && !rsp_ready) return 2'b00;
        return model_winner();
    endfunction

    task automatic drive(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic rr);
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        #1;
    endtask

    task automatic tick();
        logic [1:0] g;
        g = model_ready();
        @(posedge clk);
        if (g != 2'b00) begin
            m_valid = 1'b1;
            m_id    = g[1];
            m_last  = g[1];
            m_data  = g[1] ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_last = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        compared++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0) begin
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h id=%b, expected 0/0/0", rsp_valid, rsp_data, rsp_id);
            mismatched++;
        end
        compared++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_opcode !== 4'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            $display("[TB] FAIL reset_idle_mux: got in1=%h in2=%h op=%h r0=%b r1=%b, expected all 0",
                     alu_in1, alu_in2, alu_opcode, req0_ready, req1_ready);
            mismatched++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_add();
        drive(1, OP_ADD, 32'd5, 32'd7, 0, 4'd0, 0, 0, 1);
        compared++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || alu_opcode !== OP_ADD) begin
            $display("[TB] FAIL add_issue: got r0=%b r1=%b in1=%h in2=%h op=%h, expected 1/0/5/7/0",
                     req0_ready, req1_ready, alu_in1, alu_in2, alu_opcode);
            mismatched++;
        end
        tick();
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 1'b0) begin
            $display("[TB] FAIL add_result: got valid=%b data=%h id=%b, expected 1/0000000c/0", rsp_valid, rsp_data, rsp_id);
            mismatched++;
        end
        tick();
        compared++;
        if (rsp_valid !== 1'b0) begin
            $display("[TB] FAIL add_drain: got valid=%b, expected 0", rsp_valid);
            mismatched++;
        end
    endtask

    task automatic test_sub_and_idle();
        drive(0, 4'd0, 0, 0, 1, OP_SUB, 32'd3, 32'd5, 1);
        compared++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            $display("[TB] FAIL sub_issue: got r0=%b r1=%b, expected 0/1", req0_ready, req1_ready);
            mismatched++;
        end
        tick();
        drive(0, OP_SUB, 32'hDEAD, 32'hBEEF, 0, OP_AND, 32'h1234, 32'h5678, 1);
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFE || rsp_id !== 1'b1) begin
            $display("[TB] FAIL sub_result: got valid=%b data=%h id=%b, expected 1/fffffffe/1", rsp_valid, rsp_data, rsp_id);
            mismatched++;
        end
        compared++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_opcode !== 4'd0) begin
            $display("[TB] FAIL idle_mux: got in1=%h in2=%h op=%h, expected 0/0/0", alu_in1, alu_in2, alu_opcode);
            mismatched++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic prev_id;
        for (int i = 0; i < 8; i++) begin
            drive(1, rand_op(), $urandom, $urandom, 1, rand_op(), $urandom, $urandom, 1);
            compared++;
            if ({req1_ready, req0_ready} !== model_ready()) begin
                $display("[TB] FAIL b2b_ready[%0d]: got r1r0=%b%b, expected %b", i, req1_ready, req0_ready, model_ready());
                mismatched++;
            end
            tick();
            compared++;
            if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_data !== m_data) begin
                $display("[TB] FAIL b2b_result[%0d]: got valid=%b id=%b data=%h, expected 1/%b/%h", i, rsp_valid, rsp_id, rsp_data, m_id, m_data);
                mismatched++;
            end
`ifdef ALU_ARBITER_RR_EN
            if (i > 0) begin
                compared++;
                if (rsp_id === prev_id) begin
                    $display("[TB] FAIL b2b_alternate[%0d]: got id=%b twice, expected alternation", i, rsp_id);
                    mismatched++;
                end
            end
`else
            compared++;
            if (rsp_id !== 1'b0) begin
                $display("[TB] FAIL b2b_fixed[%0d]: got id=%b, expected 0", i, rsp_id);
                mismatched++;
            end
`endif
            prev_id = rsp_id;
        end
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] held_data;
        logic        held_id;
        drive(1, OP_XOR, $urandom, $urandom, 0, 4'd0, 0, 0, 1);
        tick();
        held_data = m_data;
        held_id   = m_id;
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'd0, 0, 0, 1, OP_SUB, $urandom, $urandom, 0);
            compared++;
            if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
                $display("[TB] FAIL stall_ready[%0d]: got r0=%b r1=%b, expected 0/0", i, req0_ready, req1_ready);
                mismatched++;
            end
            tick();
            compared++;
            if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_id !== held_id) begin
                $display("[TB] FAIL stall_hold[%0d]: got valid=%b data=%h id=%b, expected 1/%h/%b", i, rsp_valid, rsp_data, rsp_id, held_data, held_id);
                mismatched++;
            end
        end
        drive(0, 4'd0, 0, 0, 1, OP_SUB, 32'd100, 32'd1, 1);
        compared++;
        if (req1_ready !== 1'b1) begin
            $display("[TB] FAIL refill_ready: got r1=%b, expected 1", req1_ready);
            mismatched++;
        end
        tick();
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd99 || rsp_id !== 1'b1) begin
            $display("[TB] FAIL refill_result: got valid=%b data=%h id=%b, expected 1/00000063/1", rsp_valid, rsp_data, rsp_id);
            mismatched++;
        end
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), rand_op(), $urandom, $urandom, 1'($urandom), rand_op(), $urandom, $urandom, 1'($urandom));
            compared++;
            if ({req1_ready, req0_ready} !== model_ready()) begin
                $display("[TB] FAIL rand_ready[%0d]: got r1r0=%b%b, expected %b", i, req1_ready, req0_ready, model_ready());
                mismatched++;
            end
            if (model_winner() == 2'b00) begin
                compared++;
                if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_opcode !== 4'd0) begin
                    $display("[TB] FAIL rand_idle_mux[%0d]: got in1=%h in2=%h op=%h, expected 0", i, alu_in1, alu_in2, alu_opcode);
                    mismatched++;
                end
            end
            tick();
            compared++;
            if (rsp_valid !== m_valid || (m_valid && (rsp_data !== m_data || rsp_id !== m_id))) begin
                $display("[TB] FAIL rand_result[%0d]: got valid=%b data=%h id=%b, expected %b/%h/%b",
                         i, rsp_valid, rsp_data, rsp_id, m_valid, m_data, m_id);
                mismatched++;
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 4'd0, 0, 0, 1, OP_OR, $urandom, $urandom, 1);
        tick();
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compared++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0) begin
            $display("[TB] FAIL async_reset: got valid=%b data=%h id=%b, expected 0/0/0", rsp_valid, rsp_data, rsp_id);
            mismatched++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        tick();
        compared++;
        if (rsp_valid !== 1'b0) begin
            $display("[TB] FAIL stale_after_reset: got valid=%b, expected 0", rsp_valid);
            mismatched++;
        end
        drive(1, OP_ADD, 32'd1, 32'd2, 1, OP_ADD, 32'd3, 32'd4, 1);
        compared++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            $display("[TB] FAIL first_tie_after_reset: got r0=%b r1=%b, expected 1/0", req0_ready, req1_ready);
            mismatched++;
        end
        tick();
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_id !== 1'b0) begin
            $display("[TB] FAIL first_after_reset: got valid=%b data=%h id=%b, expected 1/00000003/0", rsp_valid, rsp_data, rsp_id);
            mismatched++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 0;
        test_reset();
        test_add();
        test_sub_and_idle();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
